// File: rtl/pipeline_buffer.sv
// pipeline_buffer: elastic FIFO between two pipeline stages.
//
// Upstream side uses DIR/ack_from_buffer. Downstream side uses DOR/ack_to_buffer.
// The buffer holds up to DEPTH words of WIDTH bits in FIFO order. A synchronous
// flush empties it.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   flush           synchronous discard of all entries; has priority over push/pop
//   DIR, data_in    upstream word offer
//   ack_from_buffer word accepted this cycle (not full and out of reset)
//   DOR, data_out   head word valid / head word (zero when empty)
//   ack_to_buffer   downstream takes the head word this cycle
//   count           occupancy, 0..DEPTH
//   full, empty     count == DEPTH / count == 0
//   almost_full     count >= AF_LEVEL
module pipeline_buffer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             DIR,
  output logic             ack_from_buffer,
  input  logic [WIDTH-1:0] data_in,
  output logic             DOR,
  input  logic             ack_to_buffer,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AfCnt    = (AW + 1)'(AF_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // Status comes only from the registered count, so no pass-through when full.
  always_comb begin
    full            = (count_q == DepthCnt);
    empty           = (count_q == '0);
    almost_full     = (count_q >= AfCnt);
    count           = count_q;
    ack_from_buffer = !full && reset;
    DOR             = !empty;
    data_out        = DOR ? mem_q[rd_ptr_q] : '0;
  end

  // Flush discards any same-cycle transfer on both sides.
  always_comb begin
    push = DIR && ack_from_buffer && !flush;
    pop  = DOR && ack_to_buffer && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: data_out is gated by DOR.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_pipeline_buffer.sv
// Directed self-checking bench for pipeline_buffer (WIDTH=32, DEPTH=4, AF_LEVEL=3).
module tb_pipeline_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        DIR;
  logic        ack_from_buffer;
  logic [31:0] data_in;
  logic        DOR;
  logic        ack_to_buffer;
  logic [31:0] data_out;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;

  int errors = 0;
  int checks = 0;

  pipeline_buffer #(
    .WIDTH   (32),
    .DEPTH   (4),
    .AF_LEVEL(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .DIR            (DIR),
    .ack_from_buffer(ack_from_buffer),
    .data_in        (data_in),
    .DOR            (DOR),
    .ack_to_buffer  (ack_to_buffer),
    .data_out       (data_out),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b0; DIR = 1'b1; ack_to_buffer = 1'b0; data_in = 32'h77;
    tick(); tick();
    checks++; if (ack_from_buffer !== 1'b0) begin errors++;
      $display("FAIL rst_ack: got %b want 0", ack_from_buffer); end
    checks++; if (DOR !== 1'b0) begin errors++; $display("FAIL rst_dor: got %b want 0", DOR); end
    checks++; if (data_out !== 32'h0) begin errors++;
      $display("FAIL rst_data: got %h want 0", data_out); end
    checks++; if ({empty, full, almost_full} !== 3'b100) begin errors++;
      $display("FAIL rst_flags: got e/f/af %b want 100", {empty, full, almost_full}); end
    reset = 1'b1;
    #1;
    checks++; if (ack_from_buffer !== 1'b1) begin errors++;
      $display("FAIL rel_ack: got %b want 1", ack_from_buffer); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rel_count: got %0d want 0", count); end
    DIR = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain;
    logic [2:0] exp_cnt;
    for (int i = 0; i < 4; i++) begin
      DIR = 1'b1; data_in = 32'hA0 + 32'(i);
      tick();
      exp_cnt = 3'(i + 1);
      checks++; if (count !== exp_cnt) begin errors++;
        $display("FAIL fill_count: got %0d want %0d", count, exp_cnt); end
      checks++; if (almost_full !== (i >= 2)) begin errors++;
        $display("FAIL fill_af: got %b at count %0d", almost_full, exp_cnt); end
      checks++; if (full !== (i == 3) || ack_from_buffer !== (i != 3)) begin errors++;
        $display("FAIL fill_full: got full=%b ack=%b at count %0d", full, ack_from_buffer, exp_cnt);
      end
      checks++; if (data_out !== 32'hA0 || DOR !== 1'b1) begin errors++;
        $display("FAIL fill_head: got %h dor=%b want a0 dor=1", data_out, DOR); end
    end
    data_in = 32'hA4;
    tick(); tick();
    checks++; if (count !== 3'd4 || data_out !== 32'hA0) begin errors++;
      $display("FAIL held_word: got count=%0d head=%h want 4 a0", count, data_out); end
    DIR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== 32'hA0 + 32'(i)) begin errors++;
        $display("FAIL drain_data: got %h want %h", data_out, 32'hA0 + 32'(i)); end
      ack_to_buffer = 1'b1;
      tick();
    end
    ack_to_buffer = 1'b0;
    checks++; if (empty !== 1'b1 || DOR !== 1'b0 || data_out !== 32'h0 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: got e=%b dor=%b data=%h count=%0d want 1 0 0 0",
               empty, DOR, data_out, count);
    end
  endtask

  task automatic test_streaming;
    DIR = 1'b1; ack_to_buffer = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 32'(k);
      tick();
      checks++; if (count !== 3'd1 || data_out !== 32'(k)) begin errors++;
        $display("FAIL stream_%0d: got count=%0d data=%h want 1 %h", k, count, data_out, 32'(k));
      end
    end
    DIR = 1'b0;
    tick();
    ack_to_buffer = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++;
      $display("FAIL stream_end: got e=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_simul_full;
    for (int i = 0; i < 4; i++) begin
      DIR = 1'b1; data_in = 32'hB0 + 32'(i);
      tick();
    end
    data_in = 32'hB4; ack_to_buffer = 1'b1;
    #1;
    checks++; if (ack_from_buffer !== 1'b0) begin errors++;
      $display("FAIL full_ack: got %b want 0", ack_from_buffer); end
    tick();  // pop only
    checks++; if (count !== 3'd3 || data_out !== 32'hB1) begin errors++;
      $display("FAIL full_pop: got count=%0d head=%h want 3 b1", count, data_out); end
    tick();  // push B4 and pop B1
    DIR = 1'b0;
    checks++; if (count !== 3'd3 || data_out !== 32'hB2) begin errors++;
      $display("FAIL full_both: got count=%0d head=%h want 3 b2", count, data_out); end
    tick();
    checks++; if (count !== 3'd2 || data_out !== 32'hB3) begin errors++;
      $display("FAIL full_d1: got count=%0d head=%h want 2 b3", count, data_out); end
    tick();
    checks++; if (count !== 3'd1 || data_out !== 32'hB4) begin errors++;
      $display("FAIL full_d2: got count=%0d head=%h want 1 b4", count, data_out); end
    tick();
    ack_to_buffer = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_d3: got e=%b want 1", empty); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      DIR = 1'b1; data_in = 32'hC0 + 32'(i);
      tick();
    end
    flush = 1'b1; data_in = 32'hC3; ack_to_buffer = 1'b1;
    tick();
    flush = 1'b0; DIR = 1'b0; ack_to_buffer = 1'b0;
    checks++; if (count !== 3'd0 || DOR !== 1'b0 || data_out !== 32'h0) begin errors++;
      $display("FAIL flush: got count=%0d dor=%b data=%h want 0 0 0", count, DOR, data_out); end
    DIR = 1'b1; data_in = 32'h55;
    tick();
    DIR = 1'b0;
    checks++; if (count !== 3'd1 || data_out !== 32'h55) begin errors++;
      $display("FAIL post_flush: got count=%0d head=%h want 1 55", count, data_out); end
    ack_to_buffer = 1'b1;
    tick();
    ack_to_buffer = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++;
      $display("FAIL post_flush_pop: got e=%b want 1", empty); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 2; i++) begin
      DIR = 1'b1; data_in = 32'hD0 + 32'(i);
      tick();
    end
    DIR = 1'b0;
    checks++; if (count !== 3'd2) begin errors++;
      $display("FAIL pre_areset: got count=%0d want 2", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (DOR !== 1'b0 || count !== 3'd0 || data_out !== 32'h0) begin errors++;
      $display("FAIL areset: got dor=%b count=%0d data=%h want 0 0 0", DOR, count, data_out); end
    checks++; if (ack_from_buffer !== 1'b0) begin errors++;
      $display("FAIL areset_ack: got %b want 0", ack_from_buffer); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_simul_full();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_buffer.md
# pipeline_buffer

Parametrised elastic buffer between two tinycpu pipeline stages, e.g. instruction fetch to instruction decode. It uses the stage handshake: DIR/ack on the upstream side and DOR/ack on the downstream side. It holds up to DEPTH words of WIDTH bits in FIFO order, so upstream can keep producing while downstream stalls. A synchronous flush empties it on branch or redirect.

## Interface
- WIDTH, 32, data word width in bits (≥1).
- DEPTH, 4, number of entries; power of two, ≥2. AW = log2(DEPTH).
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full is asserted (1..DEPTH).

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low. While low, all state is cleared immediately.
- flush  in  1  synchronous discard of all entries.
- DIR  in  1  upstream data ready; data_in is valid.
- ack_from_buffer  out  1  buffer accepts data_in this cycle.
- data_in  in  WIDTH  upstream word.
- DOR  out  1  buffer has a word at its head.
- ack_to_buffer  in  1  downstream takes the head word this cycle.
- data_out  out  WIDTH  head word.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.

## Operation
- Storage: register array of DEPTH×WIDTH, with write pointer wr_ptr, read pointer rd_ptr (each AW bits) and count (AW+1 bits).
- Push occurs on the rising edge when DIR && ack_from_buffer. On push, data_in is written to mem[wr_ptr] and wr_ptr increments.
- Pop occurs on the rising edge when DOR && ack_to_buffer. On pop, rd_ptr increments.
- Pointers wrap modulo DEPTH (natural AW-bit overflow). count is never derived from pointer difference alone.
- ack_from_buffer = !full && reset. It is combinational from registered count and does not depend on ack_to_buffer, so there is no pass-through when full.
- DOR = !empty.
- data_out = mem[rd_ptr] when DOR, otherwise all zeros.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including when count == 1 with the new word written behind the head.
- Ignored events:
  - DIR while full: no push, no error flag; upstream must hold data_in and DIR.
  - ack_to_buffer while empty: no pop.
- Flush has priority over everything:
  - wr_ptr, rd_ptr and count go to 0 on that edge.
  - A same-cycle push and pop are both discarded, even if the acks were asserted.
  - Array contents are not cleared, but data_out reads 0 because empty.
- Upstream protocol: once DIR is raised it stays high with data_in stable until an accepted cycle. The buffer does not check this.

## Timing
- Reset (reset low):
  - count = 0, pointers = 0.
  - DOR = 0, data_out = 0, empty = 1, full = 0.
  - almost_full = 0 (for AF_LEVEL ≥ 1).
  - ack_from_buffer = 0.
- After reset rises, ack_from_buffer = 1 in the same cycle.
- Latency: a word pushed at edge N appears on data_out with DOR = 1 after edge N. It can be popped at edge N+1 at the earliest. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- Status outputs (full, empty, almost_full, count) reflect registered state only and change only on edges or on reset.
- Reset asserted mid-operation: all contents are dropped immediately. Words held by upstream are not acknowledged.

## Test plan
- Reset/idle:
  - Stimulus: hold reset low with DIR = 1; then release.
  - Required response: during reset ack_from_buffer = 0, DOR = 0, data_out = 0. After release ack_from_buffer = 1, count = 0.
- Fill and drain, DEPTH=4:
  - Stimulus: push 0xA0..0xA3 with ack_to_buffer = 0.
  - Required response: count 1,2,3,4; almost_full rises at count 3; full = 1 and ack_from_buffer = 0 at 4.
  - Stimulus: a 5th DIR word 0xA4 is held.
  - Required response: 0xA4 is not accepted.
  - Stimulus: drain.
  - Required response: data_out 0xA0, 0xA1, 0xA2, 0xA3, then empty = 1, data_out = 0.
- Streaming with wrap:
  - Stimulus: DIR = ack_to_buffer = 1 continuously for 20 words 0..19.
  - Required response: output sequence 0..19 in order; count stays at 1 after the first push; pointers wrap with no loss.
- Simultaneous push/pop at count=1 and at full:
  - Required response: count is unchanged; the head advances in order. At full, no push occurs until the pop edge.
- Flush:
  - Stimulus: at count = 3 assert flush with DIR = 1 and ack_to_buffer = 1 in the same cycle.
  - Required response: next cycle count = 0, DOR = 0; neither word is transferred.
  - Stimulus: push 0x55.
  - Required response: 0x55 is the next output.
- Asynchronous reset mid-stream:
  - Stimulus: at count = 2, drop reset between edges.
  - Required response: DOR and count go to 0 immediately, without waiting for a clock edge.
